// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard of in-flight long-latency
// writes (loads with a fixed latency, one outstanding mul/div). It stalls
// PC and IF/ID and bubbles ID/EX on RAW, WAW and mul/div structural hazards.
// Optional build macro: HAZARD_PERF_EN adds a saturating stall-cycle counter
// (stall_count) with a synchronous clear (stall_count_clr).
//
// Stall semantics: the ID instruction issues in a cycle where id_valid=1,
// pipe_flush=0 and hazard=0. While hazard=1 the PC and IF/ID hold their
// contents and ID/EX receives a bubble; the same ID instruction is
// re-evaluated on the next cycle. pipe_flush kills the ID instruction, so
// it neither issues nor stalls.
module hazard_scoreboard #(
   parameter int NUM_REGS     = 32,
   parameter int ADDR_W       = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1_address,
   input  logic [ADDR_W-1:0] id_rs2_address,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [ADDR_W-1:0] id_rd_address,
   input  logic              id_reg_write,
   input  logic              id_is_load,
   input  logic              id_is_muldiv,
   input  logic              muldiv_done,
   input  logic [ADDR_W-1:0] muldiv_rd_address,
   input  logic              pipe_flush,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              flush_id_ex,
   output logic              muldiv_busy
`ifdef HAZARD_PERF_EN
   ,
   input  logic              stall_count_clr,
   output logic [31:0]       stall_count
`endif
);

   localparam int ADDR_SPACE = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LATENCY);

   // x0 is never tracked, so storage starts at register 1.
   logic [CNT_W-1:0]     ld_cnt [1:NUM_REGS-1];
   logic [NUM_REGS-1:1]  md_pend;

   // Busy flags cover the full address space so any address indexes safely;
   // x0 and addresses beyond NUM_REGS read as never busy.
   logic [ADDR_SPACE-1:0] busy_vec;
   logic raw_hazard;
   logic waw_hazard;
   logic struct_hazard;
   logic hazard;
   logic issue;
   logic rd_nonzero;
   logic load_alloc;
   logic md_alloc;
   logic md_issue;

   // Busy vector from registered scoreboard state only (no done bypass).
   always_comb begin
      busy_vec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         busy_vec[r] = (ld_cnt[r] != '0) | md_pend[r];
      end
   end

   // Hazard classification, issue decision and allocation strobes.
   always_comb begin
      rd_nonzero    = (id_rd_address != '0);
      raw_hazard    = (id_uses_rs1 & busy_vec[id_rs1_address]) |
                      (id_uses_rs2 & busy_vec[id_rs2_address]);
      waw_hazard    = id_reg_write & rd_nonzero & busy_vec[id_rd_address];
      struct_hazard = id_is_muldiv & muldiv_busy;
      hazard        = id_valid & ~pipe_flush &
                      (raw_hazard | waw_hazard | struct_hazard);
      issue         = id_valid & ~pipe_flush & ~hazard;
      load_alloc    = issue & id_reg_write & id_is_load & rd_nonzero;
      md_alloc      = issue & id_reg_write & id_is_muldiv & rd_nonzero;
      md_issue      = issue & id_is_muldiv;
   end

   // Stall outputs are held low while reset is asserted.
   always_comb begin
      stall_pc    = hazard & rst_n;
      stall_if_id = hazard & rst_n;
      flush_id_ex = hazard & rst_n;
   end

   // Load countdown: a new load reloads the counter, otherwise count down to 0.
   always_ff @(posedge clk) begin
      for (int r = 1; r < NUM_REGS; r++) begin
         if (!rst_n) begin
            ld_cnt[r] <= '0;
         end else if (load_alloc && (id_rd_address == ADDR_W'(r))) begin
            ld_cnt[r] <= LOAD_CNT;
         end else if (ld_cnt[r] != '0) begin
            ld_cnt[r] <= ld_cnt[r] - CNT_W'(1);
         end
      end
   end

   // Mul/div pending bits and the single-outstanding busy flag; done clears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         md_pend     <= '0;
         muldiv_busy <= 1'b0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (md_alloc && (id_rd_address == ADDR_W'(r))) begin
               md_pend[r] <= 1'b1;
            end
            if (muldiv_done && (muldiv_rd_address == ADDR_W'(r))) begin
               md_pend[r] <= 1'b0;
            end
         end
         if (md_issue) begin
            muldiv_busy <= 1'b1;
         end
         if (muldiv_done) begin
            muldiv_busy <= 1'b0;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   // Saturating count of stalled cycles; clear wins over increment.
   always_ff @(posedge clk) begin
      if (!rst_n || stall_count_clr) begin
         stall_count <= '0;
      end else if (hazard && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: drives two scoreboards (LOAD_LATENCY 1 and 3) with
// identical ID/mul-div traffic and checks them against a cycle-number based
// behavioural model, plus directed scenarios with literal expectations.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1_address;
   logic [4:0] id_rs2_address;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic [4:0] id_rd_address;
   logic       id_reg_write;
   logic       id_is_load;
   logic       id_is_muldiv;
   logic       muldiv_done;
   logic [4:0] muldiv_rd_address;
   logic       pipe_flush;

   logic [1:0] stall_pc;
   logic [1:0] stall_if_id;
   logic [1:0] flush_id_ex;
   logic [1:0] muldiv_busy_o;
`ifdef HAZARD_PERF_EN
   logic        stall_count_clr;
   logic [31:0] stall_count_o [2];
`endif

   hazard_scoreboard #(.LOAD_LATENCY(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd_address(id_rd_address), .id_reg_write(id_reg_write),
      .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
      .muldiv_done(muldiv_done), .muldiv_rd_address(muldiv_rd_address),
      .pipe_flush(pipe_flush), .stall_pc(stall_pc[0]),
      .stall_if_id(stall_if_id[0]), .flush_id_ex(flush_id_ex[0]),
      .muldiv_busy(muldiv_busy_o[0])
`ifdef HAZARD_PERF_EN
      , .stall_count_clr(stall_count_clr), .stall_count(stall_count_o[0])
`endif
   );

   hazard_scoreboard #(.LOAD_LATENCY(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd_address(id_rd_address), .id_reg_write(id_reg_write),
      .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
      .muldiv_done(muldiv_done), .muldiv_rd_address(muldiv_rd_address),
      .pipe_flush(pipe_flush), .stall_pc(stall_pc[1]),
      .stall_if_id(stall_if_id[1]), .flush_id_ex(flush_id_ex[1]),
      .muldiv_busy(muldiv_busy_o[1])
`ifdef HAZARD_PERF_EN
      , .stall_count_clr(stall_count_clr), .stall_count(stall_count_o[1])
`endif
   );

   // ---------------- scoreboard bookkeeping ----------------
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A load issued in cycle t makes rd unavailable until cycle t+L+1.
   int unsigned cyc_n = 0;
   int unsigned ready_at [2][32];
   bit          md_p     [2][32];
   bit          mb       [2];
`ifdef HAZARD_PERF_EN
   logic [31:0] pc_model [2];
`endif

   function automatic int unsigned lat(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic bit reg_busy(int k, int r);
      if (r == 0) return 1'b0;
      return (cyc_n < ready_at[k][r]) || md_p[k][r];
   endfunction

   function automatic bit model_hz(int k);
      bit raw, waw, st;
      raw = (id_uses_rs1 && reg_busy(k, int'(id_rs1_address))) ||
            (id_uses_rs2 && reg_busy(k, int'(id_rs2_address)));
      waw = id_reg_write && (id_rd_address != 0) && reg_busy(k, int'(id_rd_address));
      st  = id_is_muldiv && mb[k];
      return id_valid && !pipe_flush && (raw || waw || st);
   endfunction

   always @(posedge clk) begin
      bit hz [2];
      bit iss;
      for (int k = 0; k < 2; k++) hz[k] = model_hz(k);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
               ready_at[k][r] = 0;
               md_p[k][r]     = 1'b0;
            end
            mb[k] = 1'b0;
         end else begin
            iss = id_valid && !pipe_flush && !hz[k];
            if (iss && id_reg_write && id_is_load && id_rd_address != 0)
               ready_at[k][id_rd_address] = cyc_n + lat(k) + 1;
            if (iss && id_reg_write && id_is_muldiv && id_rd_address != 0)
               md_p[k][id_rd_address] = 1'b1;
            if (iss && id_is_muldiv) mb[k] = 1'b1;
            if (muldiv_done) begin
               md_p[k][muldiv_rd_address] = 1'b0;
               mb[k] = 1'b0;
            end
         end
`ifdef HAZARD_PERF_EN
         if (!rst_n || stall_count_clr) pc_model[k] = 0;
         else if (hz[k] && pc_model[k] != 32'hFFFF_FFFF) pc_model[k] = pc_model[k] + 1;
`endif
      end
      cyc_n++;
   end

   // ---------------- compare process (every cycle, on the falling edge) ----
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            logic e;
            e = rst_n && model_hz(k);
            check($sformatf("stall_pc_l%0d", lat(k)), 32'(stall_pc[k]), 32'(e));
            check($sformatf("stall_if_id_l%0d", lat(k)), 32'(stall_if_id[k]), 32'(e));
            check($sformatf("flush_id_ex_l%0d", lat(k)), 32'(flush_id_ex[k]), 32'(e));
            check($sformatf("muldiv_busy_l%0d", lat(k)), 32'(muldiv_busy_o[k]), 32'(mb[k]));
`ifdef HAZARD_PERF_EN
            check($sformatf("stall_count_l%0d", lat(k)), stall_count_o[k], pc_model[k]);
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      id_valid = 0; id_rs1_address = 0; id_rs2_address = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; id_rd_address = 0;
      id_reg_write = 0; id_is_load = 0; id_is_muldiv = 0;
      muldiv_done = 0; muldiv_rd_address = 0; pipe_flush = 0;
   endtask

   task automatic set_load(int rd);
      idle();
      id_valid = 1; id_reg_write = 1; id_is_load = 1; id_rd_address = 5'(rd);
   endtask

   task automatic set_mul(int rd);
      idle();
      id_valid = 1; id_reg_write = 1; id_is_muldiv = 1; id_rd_address = 5'(rd);
   endtask

   task automatic set_read(int rs1, bit u1, int rs2, bit u2);
      idle();
      id_valid = 1; id_rs1_address = 5'(rs1); id_uses_rs1 = u1;
      id_rs2_address = 5'(rs2); id_uses_rs2 = u2;
   endtask

   // Literal expectation for one cycle, then advance to just after the edge.
   task automatic tick_expect(bit e1, bit e3, bit e_mb, string name);
      #2;
      check({name, "_l1"}, 32'(stall_pc[0]), 32'(e1));
      check({name, "_l3"}, 32'(stall_pc[1]), 32'(e3));
      check({name, "_busy"}, 32'(muldiv_busy_o[0]), 32'(e_mb));
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst_n = 0;
`ifdef HAZARD_PERF_EN
      stall_count_clr = 0;
`endif
      @(posedge clk); #1;
      chk_en = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      check("reset_busy_l1", 32'(muldiv_busy_o[0]), 0);
      check("reset_busy_l3", 32'(muldiv_busy_o[1]), 0);

      // load-use on rs1
      set_load(5);         tick_expect(0, 0, 0, "ld5_issue");
      set_read(5, 1, 0, 0);
      tick_expect(1, 1, 0, "raw5_c1");
      tick_expect(0, 1, 0, "raw5_c2");
      tick_expect(0, 1, 0, "raw5_c3");
      tick_expect(0, 0, 0, "raw5_c4");

      // load-use on rs2; independent x8 never stalls
      set_load(7);         tick_expect(0, 0, 0, "ld7_issue");
      set_read(8, 1, 7, 1);
      tick_expect(1, 1, 0, "raw7_c1");
      tick_expect(0, 1, 0, "raw7_c2");
      tick_expect(0, 1, 0, "raw7_c3");
      tick_expect(0, 0, 0, "raw7_c4");
      set_load(7);         tick_expect(0, 0, 0, "ld7b_issue");
      set_read(8, 1, 8, 1);
      repeat (3) tick_expect(0, 0, 0, "indep8");

      // mul x9, dependent waits through the done cycle
      set_mul(9);          tick_expect(0, 0, 0, "mul9_issue");
      set_read(9, 1, 0, 0);
      repeat (5) tick_expect(1, 1, 1, "raw9_wait");
      muldiv_done = 1; muldiv_rd_address = 9;
      tick_expect(1, 1, 1, "raw9_done_cycle");
      muldiv_done = 0;
      tick_expect(0, 0, 0, "raw9_release");

      // structural and WAW against an outstanding mul
      set_mul(9);          tick_expect(0, 0, 0, "mul9b_issue");
      set_mul(10);         tick_expect(1, 1, 1, "struct_mul10");
      set_load(9);         tick_expect(1, 1, 1, "waw_ld9");
      set_load(0);         tick_expect(0, 0, 1, "ld_x0");
      set_read(0, 1, 0, 1); tick_expect(0, 0, 1, "read_x0");
      set_read(9, 1, 0, 0); pipe_flush = 1;
      tick_expect(0, 0, 1, "flush_raw9");
      set_load(11); pipe_flush = 1;
      tick_expect(0, 0, 1, "flush_ld11");
      set_read(11, 1, 11, 1); tick_expect(0, 0, 1, "no_alloc_11");
      set_read(9, 0, 9, 0); tick_expect(0, 0, 1, "unused_rs9");
      idle(); muldiv_done = 1; muldiv_rd_address = 9;
      tick_expect(0, 0, 1, "done9");
      set_mul(10);         tick_expect(0, 0, 0, "mul10_issue");
      idle(); muldiv_done = 1; muldiv_rd_address = 10;
      tick_expect(0, 0, 1, "done10");
      idle();              tick_expect(0, 0, 0, "idle");

      // reset mid-run with a load and a mul outstanding
      set_load(4);         tick_expect(0, 0, 0, "ld4_issue");
      set_mul(6);          tick_expect(0, 0, 0, "mul6_issue");
      set_read(4, 1, 6, 1); rst_n = 0;
      tick_expect(0, 0, 1, "rst_c1");
      tick_expect(0, 0, 0, "rst_c2");
      rst_n = 1;
      tick_expect(0, 0, 0, "post_rst_x4_x6");

`ifdef HAZARD_PERF_EN
      idle(); stall_count_clr = 1; @(posedge clk); #1;
      stall_count_clr = 0;
      set_load(5); @(posedge clk); #1;
      set_read(5, 1, 0, 0);
      repeat (4) begin @(posedge clk); #1; end
      idle(); #1;
      check("perf_three", stall_count_o[1], 32'd3);
      stall_count_clr = 1; @(posedge clk); #1;
      stall_count_clr = 0; #1;
      check("perf_clr", stall_count_o[1], 32'd0);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int kind;
         idle();
         rst_n = ($urandom_range(0, 199) != 0);
         id_valid = ($urandom_range(0, 7) != 0);
         id_rs1_address = 5'($urandom_range(0, 7));
         id_rs2_address = 5'($urandom_range(0, 7));
         id_uses_rs1 = 1'($urandom_range(0, 1));
         id_uses_rs2 = 1'($urandom_range(0, 1));
         id_rd_address = 5'($urandom_range(0, 7));
         id_reg_write = ($urandom_range(0, 3) != 0);
         kind = $urandom_range(0, 9);
         id_is_load = (kind < 4);
         id_is_muldiv = (kind == 4);
         pipe_flush = ($urandom_range(0, 15) == 0);
         if ((mb[0] || mb[1]) && $urandom_range(0, 3) == 0) begin
            muldiv_done = 1;
            muldiv_rd_address = 5'($urandom_range(0, 7));
            id_is_muldiv = 0;
         end
         @(posedge clk); #1;
      end

      idle();
      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the single-cycle load-use detector in the integer pipeline. It sits beside the ID stage and keeps a per-register scoreboard of in-flight long-latency writes: loads with a configurable latency, and one outstanding multi-cycle mul/div. It stalls PC and IF/ID and bubbles ID/EX on RAW hazards, WAW hazards and mul/div structural conflicts. It also handles branch-flush kill of the ID instruction.

Parameters:
NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS.
LOAD_LATENCY, 1, cycles after a load enters EX during which its result is not forwardable; legal range 1..7.
CNT_W, 3, countdown counter width; must hold LOAD_LATENCY.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_rs1_address  in  ADDR_W  source 1
id_rs2_address  in  ADDR_W  source 2
id_uses_rs1  in  1  rs1 actually read
id_uses_rs2  in  1  rs2 actually read
id_rd_address  in  ADDR_W  destination
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  load instruction
id_is_muldiv  in  1  multi-cycle mul/div instruction
muldiv_done  in  1  mul/div unit writes back this cycle
muldiv_rd_address  in  ADDR_W  rd of completing mul/div
pipe_flush  in  1  redirect from EX: kill the ID instruction
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
flush_id_ex  out  1  insert bubble into ID/EX
muldiv_busy  out  1  a mul/div is outstanding

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset state: all load counters 0, all muldiv-pending bits 0, muldiv_busy 0. While rst_n is low, stall_pc, stall_if_id and flush_id_ex are forced to 0.
- State per register r (1..NUM_REGS-1): ld_cnt[r] (CNT_W bits) and md_pend[r] (1 bit). Register r is busy when ld_cnt[r] != 0 or md_pend[r] = 1. Register 0 is never busy.
- RAW hazard: (id_uses_rs1 and busy(rs1)) or (id_uses_rs2 and busy(rs2)).
- WAW hazard: id_reg_write, rd != 0 and busy(rd).
- Structural hazard: id_is_muldiv and muldiv_busy.
- hazard = id_valid and not pipe_flush and (RAW or WAW or structural).
- Outputs: stall_pc = stall_if_id = flush_id_ex = hazard. They are combinational from registered state and ID inputs, with no added latency.
- Issue: issue = id_valid and not pipe_flush and not hazard.
- Next-state rules at each clock edge, in priority order:
  1. Every nonzero ld_cnt decrements by 1, saturating at 0.
  2. If issue, id_reg_write, id_is_load and rd != 0: ld_cnt[rd] <= LOAD_LATENCY. This load overrides the decrement.
  3. If issue, id_reg_write, id_is_muldiv and rd != 0: md_pend[rd] <= 1.
  4. If issue and id_is_muldiv (even when rd = 0): muldiv_busy <= 1.
  5. If muldiv_done: md_pend[muldiv_rd_address] <= 0 and muldiv_busy <= 0.
- Simultaneous events:
  - Done and new mul/div issue in the same cycle cannot occur, because muldiv_busy blocks the issue. Hazard checks use registered state only, with no bypass of muldiv_done, so a dependent instruction releases the cycle after done.
  - Set and clear of the same md_pend bit in one cycle is therefore impossible.
  - muldiv_done while muldiv_busy = 0 has no effect beyond clearing.
- pipe_flush: suppresses both issue and stall for the ID instruction. The scoreboard is untouched, because its entries belong to older instructions.
- With LOAD_LATENCY = 1, timing is identical to a classic one-bubble load-use stall.
- Non-load, non-muldiv writers allocate nothing, because their results are forwarded.
- Reset asserted mid-operation clears all state on the next edge. No pending entry survives.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, add output stall_count (32 bits) and input stall_count_clr (1 bit).
- stall_count increments each cycle hazard = 1 and saturates at 0xFFFFFFFF.
- stall_count_clr, or reset, zeroes the counter. Clear wins over increment.
- When the macro is undefined, neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- LOAD_LATENCY=1: issue load x5, then next cycle ID reads x5 via rs1 -> hazard for exactly 1 cycle; issues in the 2nd cycle.
- LOAD_LATENCY=3: load x7, then dependent on rs2=x7 -> stalls 3 consecutive cycles; an independent instruction reading x8 never stalls.
- Issue mul x9; dependent reads x9; muldiv_done with rd=9 asserted 6 cycles later -> stall holds through the done cycle and releases the cycle after; muldiv_busy 1->0 the cycle after done.
- Mul x9 outstanding; second mul x10 -> structural stall until done; load writing x9 while md_pend[9] set -> WAW stall.
- Load x0, or an instruction with id_uses_rs1=0 reading busy x5 -> no stall. pipe_flush=1 with a RAW condition present -> all stall outputs 0 and nothing allocated.
- Reset mid-run with ld_cnt[4]=2 and md_pend[6]=1 -> all outputs 0; after release, reads of x4/x6 do not stall. With HAZARD_PERF_EN, 3 stall cycles -> stall_count=3; clr -> 0.
